// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_write_sequencer: 4-bit HD44780-style byte writer with power-on config |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_write_sequencer #(
  parameter int unsigned T_SETUP    = 2,
  parameter int unsigned T_E_HIGH   = 12,
  parameter int unsigned T_NIB_GAP  = 50,
  parameter int unsigned T_BYTE_GAP = 2000,
  parameter int unsigned T_CLEAR    = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [3:0] lcd_db_o,
  output logic       busy_o,
  output logic       cfg_done_o
);

  typedef enum logic [3:0] {
    WAIT_INIT = 4'd0,
    CFG_LOAD  = 4'd1,
    SETUP_HI  = 4'd2,
    E_HI      = 4'd3,
    GAP_NIB   = 4'd4,
    SETUP_LO  = 4'd5,
    E_LO      = 4'd6,
    GAP_BYTE  = 4'd7,
    IDLE      = 4'd8
  } state_t;

  localparam logic [16:0] C_SETUP_LAST = 17'(T_SETUP - 1);
  localparam logic [16:0] C_E_LAST     = 17'(T_E_HIGH - 1);
  localparam logic [16:0] C_NIB_LAST   = 17'(T_NIB_GAP - 1);
  localparam logic [16:0] C_BYTE_LAST  = 17'(T_BYTE_GAP - 1);
  localparam logic [16:0] C_CLEAR_LAST = 17'(T_CLEAR - 1);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        cfg_done_q, cfg_done_d;

  logic [7:0]  rom_byte;
  logic [16:0] dwell_last;
  logic        dwell_done;
  logic        is_clear;

  always_comb begin
    case (idx_q)
      2'd0:    rom_byte = 8'h28;
      2'd1:    rom_byte = 8'h06;
      2'd2:    rom_byte = 8'h0C;
      default: rom_byte = 8'h01;
    endcase
  end

  // The clear command needs the long settle time whoever issued it.
  assign is_clear = (byte_q == 8'h01) && !rs_q;

  always_comb begin
    case (state_q)
      SETUP_HI, SETUP_LO: dwell_last = C_SETUP_LAST;
      E_HI, E_LO:         dwell_last = C_E_LAST;
      GAP_NIB:            dwell_last = C_NIB_LAST;
      GAP_BYTE:           dwell_last = is_clear ? C_CLEAR_LAST : C_BYTE_LAST;
      default:            dwell_last = '0;
    endcase
  end

  assign dwell_done = (cnt_q == dwell_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_INIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      rs_q       <= rs_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 17'd1;
    idx_d      = idx_q;
    byte_d     = byte_q;
    rs_d       = rs_q;
    cfg_done_d = cfg_done_q;
    case (state_q)
      WAIT_INIT: begin
        if (init_done_i) begin
          state_d = CFG_LOAD;
          idx_d   = 2'd0;
        end
      end
      CFG_LOAD: begin
        byte_d  = rom_byte;
        rs_d    = 1'b0;
        state_d = SETUP_HI;
      end
      SETUP_HI: if (dwell_done) state_d = E_HI;
      E_HI:     if (dwell_done) state_d = GAP_NIB;
      GAP_NIB:  if (dwell_done) state_d = SETUP_LO;
      SETUP_LO: if (dwell_done) state_d = E_LO;
      E_LO:     if (dwell_done) state_d = GAP_BYTE;
      GAP_BYTE: begin
        if (dwell_done) begin
          if (!cfg_done_q && idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = CFG_LOAD;
          end else begin
            if (!cfg_done_q) cfg_done_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (req_valid_i) begin
          byte_d  = req_data_i;
          rs_d    = req_rs_i;
          state_d = SETUP_HI;
        end
      end
      default: state_d = WAIT_INIT;
    endcase
    if (state_d != state_q || state_q == WAIT_INIT || state_q == IDLE) cnt_d = '0;
  end

  always_comb begin
    lcd_e_o  = (state_q == E_HI) || (state_q == E_LO);
    lcd_rw_o = 1'b0;
    case (state_q)
      SETUP_HI, E_HI: lcd_db_o = byte_q[7:4];
      SETUP_LO, E_LO: lcd_db_o = byte_q[3:0];
      default:        lcd_db_o = 4'h0;
    endcase
    case (state_q)
      SETUP_HI, E_HI, GAP_NIB, SETUP_LO, E_LO, GAP_BYTE: lcd_rs_o = rs_q;
      default:                                           lcd_rs_o = 1'b0;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign cfg_done_o  = cfg_done_q;

endmodule
`default_nettype wire
